// File: rtl/fixed_to_float_packer.sv
// rtl/fixed_to_float_packer.sv - signed fixed-point to IEEE-754 single packer
//
// Purpose: packs a signed two's-complement fixed-point value (FRAC_BITS
// fractional bits, Q1.30 at default) into an IEEE-754 single-precision float.
// The magnitude is normalised one left shift per cycle, then rounded to
// nearest-even. Valid/ready handshake on both sides, one conversion at a time.
//
// Ports:
//   clk        in   1   system clock, rising edge
//   rst        in   1   asynchronous active-high reset
//   in_valid   in   1   in_data is valid
//   in_ready   out  1   block can accept an input (IDLE only)
//   in_data    in   32  signed fixed-point value
//   out_valid  out  1   out_data holds a packed result
//   out_ready  in   1   consumer accepts out_data
//   out_data   out  32  {sign, exp[7:0], mant[22:0]}
module fixed_to_float_packer #(
  parameter int FRAC_BITS = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data
);

  // Biased exponent of bit 31 of the magnitude before any shift.
  localparam logic [7:0] EXP_INIT = 8'(127 + (31 - FRAC_BITS));

  typedef enum logic [1:0] {IDLE, NORM, ROUND, HOLD} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_mag;
  logic [7:0]  r_exp;
  logic        r_sign;
  logic [31:0] r_data;

  logic        w_zero;
  logic [31:0] w_abs;
  logic [22:0] w_mant;
  logic        w_guard;
  logic        w_sticky;
  logic        w_round_up;
  logic [23:0] w_mant_inc;
  logic [22:0] w_mant_rnd;
  logic [7:0]  w_exp_rnd;

  assign w_zero = (in_data == 32'd0);
  // Two's-complement negate; 0x80000000 stays 0x80000000, which is the
  // correct unsigned magnitude.
  assign w_abs  = in_data[31] ? (~in_data + 32'd1) : in_data;

  assign w_mant     = r_mag[30:8];
  assign w_guard    = r_mag[7];
  assign w_sticky   = |r_mag[6:0];
  assign w_round_up = w_guard & (w_sticky | w_mant[0]);
  assign w_mant_inc = {1'b0, w_mant} + {23'd0, w_round_up};
  // On carry-out the low 23 bits are already zero, so only exp needs a bump.
  assign w_mant_rnd = w_mant_inc[22:0];
  assign w_exp_rnd  = r_exp + {7'd0, w_mant_inc[23]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        // Zero skips normalisation and goes straight to ROUND, which packs
        // it to +0 because mag and exp are cleared on accept.
        if (in_valid) begin
          w_next = w_zero ? ROUND : NORM;
        end
      end
      NORM: begin
        if (r_mag[31]) begin
          w_next = ROUND;
        end
      end
      ROUND: begin
        w_next = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mag  <= 32'd0;
      r_exp  <= 8'd0;
      r_sign <= 1'b0;
      r_data <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_sign <= in_data[31];
            r_mag  <= w_abs;
            r_exp  <= w_zero ? 8'd0 : EXP_INIT;
          end
        end
        NORM: begin
          if (!r_mag[31]) begin
            r_mag <= r_mag << 1;
            r_exp <= r_exp - 8'd1;
          end
        end
        ROUND: begin
          r_data <= {r_sign, w_exp_rnd, w_mant_rnd};
        end
        default: begin
        end
      endcase
    end
  end

  assign out_data = r_data;

endmodule

// File: tb/tb_fixed_to_float_packer.sv
// tb/tb_fixed_to_float_packer.sv - self-checking bench for fixed_to_float_packer
module tb_fixed_to_float_packer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  int n_vec;
  int n_err;

  logic [31:0] sb_q[$];

  typedef struct {
    logic [31:0] din;
    logic [31:0] dout;
    int          lat;
  } vec_t;

  vec_t vecs[11];

  fixed_to_float_packer #(.FRAC_BITS(30)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Called at posedge+1 with the DUT in IDLE. Applies one input, measures
  // latency, optionally stalls the consumer with a competing in_valid, then
  // completes the output handshake.
  task automatic run_vec(input logic [31:0] d, input logic [31:0] e, input int lat,
                         input int stall);
    int          cyc;
    logic [31:0] exp_out;
    chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
    in_valid  = 1'b1;
    in_data   = d;
    out_ready = (stall == 0);
    @(posedge clk); #1;
    sb_q.push_back(e);
    in_valid = 1'b0;
    in_data  = 32'd0;
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk($sformatf("latency_%h", d), 32'(cyc), 32'(lat));
    exp_out = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hDEADBEEF;
    chk($sformatf("out_data_%h", d), out_data, exp_out);
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h40000000;
      @(posedge clk); #1;
      chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_out_data", out_data, exp_out);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    in_data   = 32'd0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("valid_drop", {31'd0, out_valid}, 32'd0);
    chk("in_ready_after", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int seen;
    n_vec = 0;
    n_err = 0;

    vecs[0]  = '{32'h40000000, 32'h3F800000, 3};
    vecs[1]  = '{32'hC0000000, 32'hBF800000, 3};
    vecs[2]  = '{32'h26DD3B6A, 32'h3F1B74EE, 4};
    vecs[3]  = '{32'h80000000, 32'hC0000000, 2};
    vecs[4]  = '{32'h00000000, 32'h00000000, 1};
    vecs[5]  = '{32'h00000001, 32'h30800000, 33};
    vecs[6]  = '{32'h7FFFFFFF, 32'h40000000, 3};
    vecs[7]  = '{32'h40000040, 32'h3F800000, 3};
    vecs[8]  = '{32'h400000C0, 32'h3F800002, 3};
    vecs[9]  = '{32'hFFFFFFFF, 32'hB0800000, 33};
    vecs[10] = '{32'h20000000, 32'h3F000000, 4};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 32'd0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_out_data", out_data, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < 11; i++) begin
      run_vec(vecs[i].din, vecs[i].dout, vecs[i].lat, 0);
    end

    // Backpressure: 10 stalled cycles with a competing in_valid.
    run_vec(32'h26DD3B6A, 32'h3F1B74EE, 4, 10);
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("no_accept_while_busy", 32'(seen), 32'd0);

    // Reset during normalisation of the smallest nonzero input.
    in_valid = 1'b1;
    in_data  = 32'h00000001;
    @(posedge clk); #1;
    sb_q.push_back(32'h30800000);
    in_valid = 1'b0;
    in_data  = 32'd0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    sb_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("abort_no_output", 32'(seen), 32'd0);
    run_vec(32'h40000000, 32'h3F800000, 3, 0);

    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
